// File: rtl/bsr_pkg.sv
// rtl/bsr_pkg.sv - shared types and constants for the BSR block reader
package bsr_pkg;

  localparam int BLK_DIM   = 8;
  localparam int BLK_BYTES = 64;
  localparam int SUB_W     = $clog2(BLK_DIM);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RP0,
    ST_RP1,
    ST_ROW,
    ST_CI,
    ST_BLK,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } bsr_rd_state_t;

  typedef struct packed {
    logic [63:0]      data;
    logic [15:0]      block_row;
    logic [15:0]      block_col;
    logic [SUB_W-1:0] sub_row;
    logic             last_beat;
    logic             last_in_row;
  } bsr_beat_t;

endpackage

// File: rtl/bsr_skid_fifo.sv
// rtl/bsr_skid_fifo.sv - small valid/ready beat buffer exposing its occupancy
module bsr_skid_fifo
  import bsr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_tvalid_i,
  input  bsr_beat_t                  s_tdata_i,
  output logic                       m_tvalid_o,
  input  logic                       m_tready_i,
  output bsr_beat_t                  m_tdata_o,
  output logic [$clog2(DEPTH+1)-1:0] occ_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  bsr_beat_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop        = m_tvalid_o && m_tready_i;
  assign push       = s_tvalid_i && ((cnt_q != CW'(DEPTH)) || pop);
  assign m_tvalid_o = (cnt_q != '0);
  assign m_tdata_o  = m_tvalid_o ? mem_q[rd_q] : '0;
  assign occ_o      = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) wr_d = ptr_inc(wr_q);
    if (pop)  rd_d = ptr_inc(rd_q);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s_tdata_i;
  end

endmodule

// File: rtl/bsr_block_reader.sv
// rtl/bsr_block_reader.sv - CSR-order BSR walker streaming 8-byte block rows; BSR_READER_PERF_EN adds stall/meta counters
module bsr_block_reader
  import bsr_pkg::*;
#(
  parameter int MAX_BLOCKS    = 65536,
  parameter int ROW_PTR_DEPTH = 256,
  parameter int BLK_ROWS      = 8,
  parameter int SKID_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_block_rows,
  input  logic [15:0] num_block_cols,
  output logic        row_ptr_re,
  output logic [15:0] row_ptr_raddr,
  input  logic [31:0] row_ptr_rdata,
  output logic        col_idx_re,
  output logic [15:0] col_idx_raddr,
  input  logic [15:0] col_idx_rdata,
  output logic        block_re,
  output logic [18:0] block_raddr,
  input  logic [63:0] block_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [15:0] out_block_row,
  output logic [15:0] out_block_col,
  output logic [2:0]  out_sub_row,
  output logic        out_last_beat,
  output logic        out_last_in_row,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] blocks_read
`ifdef BSR_READER_PERF_EN
  , output logic [31:0] stall_cycles
  , output logic [31:0] meta_cycles
`endif
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  bsr_rd_state_t state_q, state_d;
  logic [15:0] rows_q, rows_d, cols_q, cols_d;
  logic [15:0] r_q, r_d, k_q, k_d, col_q, col_d;
  logic [31:0] cur_start_q, cur_start_d, cur_end_q, cur_end_d;
  logic [2:0]  sub_q, sub_d;
  logic        cap_start_q, cap_start_d;
  logic        ci_wait_q, ci_wait_d;
  logic        error_q, error_d;
  logic [31:0] blocks_q, blocks_d;
  logic        infl_q, infl_d;
  logic [15:0] tag_row_q, tag_row_d, tag_col_q, tag_col_d;
  logic [2:0]  tag_sub_q, tag_sub_d;
  logic        tag_lb_q, tag_lb_d, tag_lir_q, tag_lir_d;

  logic             fifo_valid, fifo_pop, issue_ok, last_sub;
  logic [31:0]      k_inc;
  bsr_beat_t        fifo_head, push_beat;
  logic [OCC_W-1:0] occ;

  assign fifo_pop = fifo_valid && out_ready;
  assign k_inc    = {16'd0, k_q} + 32'd1;
  assign last_sub = (sub_q == 3'(BLK_ROWS - 1));
  // A slot freed by this cycle's pop counts, so a single stream sustains 1 beat/cycle.
  assign issue_ok = (int'(occ) + int'(infl_q)) < (SKID_DEPTH + int'(fifo_pop));

  always_comb begin
    push_beat             = '0;
    push_beat.data        = block_rdata;
    push_beat.block_row   = tag_row_q;
    push_beat.block_col   = tag_col_q;
    push_beat.sub_row     = tag_sub_q;
    push_beat.last_beat   = tag_lb_q;
    push_beat.last_in_row = tag_lir_q;
  end

  bsr_skid_fifo #(.DEPTH(SKID_DEPTH)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .s_tvalid_i (infl_q),
    .s_tdata_i  (push_beat),
    .m_tvalid_o (fifo_valid),
    .m_tready_i (out_ready),
    .m_tdata_o  (fifo_head),
    .occ_o      (occ)
  );

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    r_d         = r_q;
    k_d         = k_q;
    col_d       = col_q;
    cur_start_d = cur_start_q;
    cur_end_d   = cur_end_q;
    sub_d       = sub_q;
    cap_start_d = 1'b0;
    ci_wait_d   = 1'b0;
    error_d     = error_q;
    blocks_d    = blocks_q;
    infl_d      = 1'b0;
    tag_row_d   = tag_row_q;
    tag_col_d   = tag_col_q;
    tag_sub_d   = tag_sub_q;
    tag_lb_d    = tag_lb_q;
    tag_lir_d   = tag_lir_q;
    row_ptr_re    = 1'b0;
    row_ptr_raddr = '0;
    col_idx_re    = 1'b0;
    col_idx_raddr = k_q;
    block_re      = 1'b0;
    block_raddr   = 19'(k_q) * 19'(BLK_ROWS) + 19'(sub_q);

    if (fifo_pop && fifo_head.last_beat) blocks_d = blocks_q + 32'd1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rows_d   = num_block_rows;
          cols_d   = num_block_cols;
          blocks_d = '0;
          error_d  = 1'b0;
          r_d      = '0;
          if (num_block_rows == 16'd0)
            state_d = ST_DRAIN;
          else if ({16'd0, num_block_rows} > 32'(ROW_PTR_DEPTH - 1))
            state_d = ST_ERR;
          else
            state_d = ST_RP0;
        end
      end
      ST_RP0: begin
        row_ptr_re  = 1'b1;
        cap_start_d = 1'b1;
        state_d     = ST_RP1;
      end
      ST_RP1: begin
        if (cap_start_q) cur_start_d = row_ptr_rdata;
        row_ptr_re    = 1'b1;
        row_ptr_raddr = r_q + 16'd1;
        state_d       = ST_ROW;
      end
      ST_ROW: begin
        if (row_ptr_rdata < cur_start_q || row_ptr_rdata > 32'(MAX_BLOCKS)) begin
          state_d = ST_ERR;
        end else if (row_ptr_rdata == cur_start_q) begin
          r_d     = r_q + 16'd1;
          state_d = ((r_q + 16'd1) == rows_q) ? ST_DRAIN : ST_RP1;
        end else begin
          cur_end_d = row_ptr_rdata;
          k_d       = cur_start_q[15:0];
          state_d   = ST_CI;
        end
      end
      ST_CI: begin
        // First cycle issues the read, second cycle checks the returned index.
        if (!ci_wait_q) begin
          col_idx_re = 1'b1;
          ci_wait_d  = 1'b1;
        end else if (col_idx_rdata >= cols_q) begin
          state_d = ST_ERR;
        end else begin
          col_d   = col_idx_rdata;
          sub_d   = '0;
          state_d = ST_BLK;
        end
      end
      ST_BLK: begin
        if (issue_ok) begin
          block_re  = 1'b1;
          infl_d    = 1'b1;
          tag_row_d = r_q;
          tag_col_d = col_q;
          tag_sub_d = sub_q;
          tag_lb_d  = last_sub;
          tag_lir_d = last_sub && (k_inc == cur_end_q);
          sub_d     = sub_q + 3'd1;
          if (last_sub) begin
            k_d = k_q + 16'd1;
            if (k_inc < cur_end_q) begin
              state_d = ST_CI;
            end else begin
              cur_start_d = cur_end_q;
              r_d         = r_q + 16'd1;
              state_d     = ((r_q + 16'd1) == rows_q) ? ST_DRAIN : ST_RP1;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (!fifo_valid && !infl_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (!fifo_valid && !infl_q) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      r_q         <= '0;
      k_q         <= '0;
      col_q       <= '0;
      cur_start_q <= '0;
      cur_end_q   <= '0;
      sub_q       <= '0;
      cap_start_q <= 1'b0;
      ci_wait_q   <= 1'b0;
      error_q     <= 1'b0;
      blocks_q    <= '0;
      infl_q      <= 1'b0;
      tag_row_q   <= '0;
      tag_col_q   <= '0;
      tag_sub_q   <= '0;
      tag_lb_q    <= 1'b0;
      tag_lir_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      r_q         <= r_d;
      k_q         <= k_d;
      col_q       <= col_d;
      cur_start_q <= cur_start_d;
      cur_end_q   <= cur_end_d;
      sub_q       <= sub_d;
      cap_start_q <= cap_start_d;
      ci_wait_q   <= ci_wait_d;
      error_q     <= error_d;
      blocks_q    <= blocks_d;
      infl_q      <= infl_d;
      tag_row_q   <= tag_row_d;
      tag_col_q   <= tag_col_d;
      tag_sub_q   <= tag_sub_d;
      tag_lb_q    <= tag_lb_d;
      tag_lir_q   <= tag_lir_d;
    end
  end

  assign out_valid       = fifo_valid;
  assign out_data        = fifo_head.data;
  assign out_block_row   = fifo_head.block_row;
  assign out_block_col   = fifo_head.block_col;
  assign out_sub_row     = fifo_head.sub_row;
  assign out_last_beat   = fifo_head.last_beat;
  assign out_last_in_row = fifo_head.last_in_row;
  assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done            = (state_q == ST_DONE);
  assign error           = error_q;
  assign blocks_read     = blocks_q;

`ifdef BSR_READER_PERF_EN
  logic [31:0] stall_q, stall_d, meta_q, meta_d;

  always_comb begin
    stall_d = stall_q;
    meta_d  = meta_q;
    if (state_q == ST_IDLE && start) begin
      stall_d = '0;
      meta_d  = '0;
    end else begin
      if (fifo_valid && !out_ready && stall_q != '1) stall_d = stall_q + 32'd1;
      if ((state_q == ST_RP0 || state_q == ST_RP1 || state_q == ST_CI) && meta_q != '1)
        meta_d = meta_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      meta_q  <= '0;
    end else begin
      stall_q <= stall_d;
      meta_q  <= meta_d;
    end
  end

  assign stall_cycles = stall_q;
  assign meta_cycles  = meta_q;
`endif

endmodule

// File: tb/tb_bsr_block_reader.sv
// tb/tb_bsr_block_reader.sv - randomized bench for bsr_block_reader against a CSR traversal model
module tb_bsr_block_reader;

  localparam longint MAX_BLK = 65536;

  typedef struct packed {
    logic [63:0] data;
    logic [15:0] row;
    logic [15:0] col;
    logic [2:0]  sub;
    logic        lb;
    logic        lir;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [15:0] num_block_rows, num_block_cols;
  logic        row_ptr_re, col_idx_re, block_re;
  logic [15:0] row_ptr_raddr, col_idx_raddr;
  logic [18:0] block_raddr;
  logic [31:0] row_ptr_rdata;
  logic [15:0] col_idx_rdata;
  logic [63:0] block_rdata;
  logic        out_valid, out_last_beat, out_last_in_row, busy, done, error;
  logic [63:0] out_data;
  logic [15:0] out_block_row, out_block_col;
  logic [2:0]  out_sub_row;
  logic [31:0] blocks_read;
`ifdef BSR_READER_PERF_EN
  logic [31:0] stall_cycles, meta_cycles;
`endif

  always #5 clk = ~clk;

  bsr_block_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .num_block_rows(num_block_rows), .num_block_cols(num_block_cols),
    .row_ptr_re(row_ptr_re), .row_ptr_raddr(row_ptr_raddr), .row_ptr_rdata(row_ptr_rdata),
    .col_idx_re(col_idx_re), .col_idx_raddr(col_idx_raddr), .col_idx_rdata(col_idx_rdata),
    .block_re(block_re), .block_raddr(block_raddr), .block_rdata(block_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_block_row(out_block_row), .out_block_col(out_block_col), .out_sub_row(out_sub_row),
    .out_last_beat(out_last_beat), .out_last_in_row(out_last_in_row),
    .busy(busy), .done(done), .error(error), .blocks_read(blocks_read)
`ifdef BSR_READER_PERF_EN
    , .stall_cycles(stall_cycles), .meta_cycles(meta_cycles)
`endif
  );

  logic [31:0] rp_mem [256];
  logic [15:0] ci_mem [256];

  always @(posedge clk) begin
    if (row_ptr_re) row_ptr_rdata <= rp_mem[row_ptr_raddr[7:0]];
    if (col_idx_re) col_idx_rdata <= ci_mem[col_idx_raddr[7:0]];
    if (block_re)   block_rdata   <= {8{block_raddr[7:0]}};
  end

  int    tests = 0, fails = 0, done_cnt = 0, rcv = 0, lir_cnt = 0;
  bit    chk_en = 0, bp_en = 0, held = 0;
  beat_t held_b;
  beat_t exp_q [$];

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    beat_t obs, e;
    obs = {out_data, out_block_row, out_block_col, out_sub_row, out_last_beat, out_last_in_row};
    if (!chk_en) begin
      held = 0;
    end else begin
      if (held) begin
        tests++;
        if (!out_valid || obs !== held_b) begin
          fails++;
          $display("FAIL hold: valid=%0b beat=%h required %h", out_valid, obs, held_b);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_beat: got %h required none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            fails++;
            $display("FAIL beat%0d: got %h required %h", rcv, obs, e);
          end
        end
        rcv++;
        if (out_last_in_row) lir_cnt++;
      end
      held   = out_valid && !out_ready;
      held_b = obs;
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Expected beats straight from the CSR definition: rows in order, blocks in order, 8 rows each.
  task automatic build_model(input int rows, input int cols, output bit err);
    beat_t b;
    exp_q.delete();
    err = 0;
    for (int r = 0; r < rows; r++) begin
      longint s, e;
      s = rp_mem[r];
      e = rp_mem[r+1];
      if (e < s || e > MAX_BLK) begin err = 1; break; end
      for (longint k = s; k < e; k++) begin
        if (int'(ci_mem[int'(k)]) >= cols) begin err = 1; break; end
        for (int sub = 0; sub < 8; sub++) begin
          b.data = {8{8'((k * 8 + sub) & 255)}};
          b.row  = 16'(r);
          b.col  = ci_mem[int'(k)];
          b.sub  = 3'(sub);
          b.lb   = (sub == 7);
          b.lir  = (sub == 7) && (k == e - 1);
          exp_q.push_back(b);
        end
      end
      if (err) break;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin rp_mem[i] = 0; ci_mem[i] = 0; end
  endtask

  task automatic set_pass1();
    clear_mem();
    rp_mem[0] = 0; rp_mem[1] = 1; rp_mem[2] = 3;
    ci_mem[0] = 2; ci_mem[1] = 0; ci_mem[2] = 3;
  endtask

  task automatic run_pass(input string name, input int rows, input int cols, input bit bp, input bit dbl);
    bit exp_err;
    int nblk, cyc;
    build_model(rows, cols, exp_err);
    nblk = exp_q.size() / 8;
    done_cnt = 0; lir_cnt = 0;
    bp_en = bp;
    @(posedge clk); #1;
    num_block_rows = 16'(rows); num_block_cols = 16'(cols); start = 1;
    @(posedge clk); #1;
    start = 0;
    chk({name, "_busy"}, busy, 1);
    chk({name, "_errclr"}, error, 0);
    if (dbl) begin
      repeat (3) @(posedge clk);
      #1; num_block_rows = 16'(rows + 3); start = 1;
      @(posedge clk); #1; start = 0; num_block_rows = 16'(rows);
    end
    cyc = 0;
    while (busy && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    chk({name, "_timeout"}, cyc < 5000, 1);
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_done"}, done_cnt, exp_err ? 0 : 1);
    chk({name, "_error"}, error, exp_err);
    chk({name, "_blocks"}, blocks_read, nblk);
    bp_en = 0;
  endtask

  initial begin
    bit e;
    int cyc, rows, cols, tot;
    rst = 1; start = 0; num_block_rows = 0; num_block_cols = 0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_blocks", blocks_read, 0);
    rst = 0; chk_en = 1;

    set_pass1();
    build_model(2, 4, e);
    chk("m1_len", exp_q.size(), 24);
    chk("m1_lir7", exp_q[7].lir, 1);
    chk("m1_lir15", exp_q[15].lir, 0);
    chk("m1_col8", exp_q[8].col, 0);
    chk("m1_data23", exp_q[23].data, 64'h1717171717171717);
    run_pass("p1", 2, 4, 0, 0);
    chk("p1_lir_cnt", lir_cnt, 2);
    run_pass("p1bp", 2, 4, 1, 0);

    clear_mem();
    rp_mem[0] = 0; rp_mem[1] = 0; rp_mem[2] = 1; rp_mem[3] = 1; ci_mem[0] = 1;
    build_model(3, 4, e);
    chk("m_empty_len", exp_q.size(), 8);
    chk("m_empty_row", exp_q[0].row, 1);
    run_pass("empty", 3, 4, 0, 0);

    clear_mem();
    rp_mem[0] = 0; rp_mem[1] = 2; rp_mem[2] = 1; ci_mem[0] = 1; ci_mem[1] = 2;
    build_model(2, 4, e);
    chk("m_rperr", e, 1);
    run_pass("rperr", 2, 4, 1, 0);

    clear_mem();
    rp_mem[0] = 0; rp_mem[1] = 1; ci_mem[0] = 4;
    run_pass("colerr", 1, 4, 0, 0);

    set_pass1();
    run_pass("clr", 2, 4, 0, 0);
    run_pass("zero", 0, 4, 0, 0);
    run_pass("dbl", 2, 4, 0, 1);

    set_pass1();
    build_model(2, 4, e);
    rcv = 0;
    @(posedge clk); #1;
    num_block_rows = 2; num_block_cols = 4; start = 1;
    @(posedge clk); #1; start = 0;
    cyc = 0;
    while (rcv < 12 && cyc < 500) begin @(posedge clk); #1; cyc++; end
    chk("rstmid_wait", cyc < 500, 1);
    chk_en = 0; rst = 1;
    @(posedge clk); #1; rst = 0;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_busy", busy, 0);
    exp_q.delete(); chk_en = 1;
    run_pass("after_rst", 2, 4, 0, 0);

    for (int it = 0; it < 8; it++) begin
      clear_mem();
      rows = $urandom_range(1, 4);
      cols = $urandom_range(1, 8);
      rp_mem[0] = $urandom_range(0, 3);
      for (int r = 0; r < rows; r++) rp_mem[r+1] = rp_mem[r] + $urandom_range(0, 3);
      tot = int'(rp_mem[rows]);
      for (int k = 0; k < tot; k++)
        ci_mem[k] = ($urandom_range(0, 15) == 0) ? 16'(cols) : 16'($urandom_range(0, cols - 1));
      run_pass($sformatf("rnd%0d", it), rows, cols, 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
